// File: rtl/shift_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_pkg : opcode/state types and chunk-size helper for shifter   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package shift_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int chunk_len(input int rem, input int step);
    return (rem < step) ? rem : step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_mask_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_mask_gen : amount -> right-shift fill mask (top n bits set)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module shift_mask_gen #(
  parameter int WIDTH = 16,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic [SHW-1:0]   i_amt,
  output logic [WIDTH-1:0] o_mask
);

  // Bit i is filled when the shift reaches down to it: n >= WIDTH - i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int unsigned c_THR = WIDTH - i;
    assign o_mask[i] = ({{(32-SHW){1'b0}}, i_amt} >= c_THR);
  end

endmodule
`default_nettype wire

// File: rtl/shift_reg_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_reg_iter : command-driven iterative shift/rotate register    |
// | Config macro: SHIFT_ROTATE_EN (enables ROL/ROR)   Rev 1.0          |
// +--------------------------------------------------------------------+
module shift_reg_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [SHW-1:0]   cmd_amt,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] dout,
  output logic             shout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           r_state, w_state_nx;
  op_e              r_op, w_op_nx, w_cur_op;
  logic [SHW-1:0]   r_rem, w_rem_nx, w_cur_rem, w_chunk, w_hi_idx, w_lo_idx;
  logic [WIDTH-1:0] r_dout, w_dout_nx, w_mask, w_sll, w_srl, w_sra;
  logic             r_shout, w_shout_nx, r_done, w_done_nx, r_err, w_err_nx;
  logic             w_accept, w_active;

  assign cmd_ready = (r_state == IDLE) & rst_n;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_active  = w_accept | (r_state == BUSY);
  assign w_cur_op  = (r_state == BUSY) ? r_op  : op_e'(cmd_op);
  assign w_cur_rem = (r_state == BUSY) ? r_rem : cmd_amt;
  assign w_chunk   = SHW'(chunk_len(int'(w_cur_rem), STEP));

  shift_mask_gen #(.WIDTH(WIDTH)) u_mask (
    .i_amt  (w_chunk),
    .o_mask (w_mask)
  );

  assign w_sll    = r_dout << w_chunk;
  assign w_srl    = r_dout >> w_chunk;
  assign w_sra    = w_srl | (r_dout[WIDTH-1] ? w_mask : '0);
  // Index of the last bit to leave for a left / right move of w_chunk bits.
  assign w_hi_idx = SHW'(WIDTH - int'(w_chunk));
  assign w_lo_idx = w_chunk - SHW'(1);

`ifdef SHIFT_ROTATE_EN
  logic [WIDTH-1:0] w_rol, w_ror;
  assign w_rol = (r_dout << w_chunk) | (r_dout >> ((SHW+1)'(WIDTH) - {1'b0, w_chunk}));
  assign w_ror = (r_dout >> w_chunk) | (r_dout << ((SHW+1)'(WIDTH) - {1'b0, w_chunk}));
`endif

  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_rem_nx   = r_rem;
    w_dout_nx  = r_dout;
    w_shout_nx = r_shout;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    if (w_active) begin
      w_op_nx = w_cur_op;
      case (w_cur_op)
        OP_NOP:  w_done_nx = 1'b1;
        OP_LOAD: begin w_dout_nx = load_data; w_done_nx = 1'b1; end
        OP_CLR:  begin w_dout_nx = '0;        w_done_nx = 1'b1; end
`ifndef SHIFT_ROTATE_EN
        OP_ROL, OP_ROR: begin w_done_nx = 1'b1; w_err_nx = 1'b1; end
`endif
        default: begin
          w_rem_nx = w_cur_rem - w_chunk;
          if (w_cur_rem != '0) begin
            case (w_cur_op)
              OP_SLL: begin w_dout_nx = w_sll; w_shout_nx = r_dout[w_hi_idx]; end
              OP_SRL: begin w_dout_nx = w_srl; w_shout_nx = r_dout[w_lo_idx]; end
              OP_SRA: begin w_dout_nx = w_sra; w_shout_nx = r_dout[w_lo_idx]; end
`ifdef SHIFT_ROTATE_EN
              OP_ROL: begin w_dout_nx = w_rol; w_shout_nx = r_dout[w_hi_idx]; end
              OP_ROR: begin w_dout_nx = w_ror; w_shout_nx = r_dout[w_lo_idx]; end
`endif
              default: ;
            endcase
          end
          if (w_rem_nx == '0) begin
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = BUSY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_NOP;
      r_rem   <= '0;
      r_dout  <= '0;
      r_shout <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_op    <= w_op_nx;
      r_rem   <= w_rem_nx;
      r_dout  <= w_dout_nx;
      r_shout <= w_shout_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end

  assign dout  = r_dout;
  assign shout = r_shout;
  assign busy  = (r_state == BUSY);
  assign done  = r_done;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shift_reg_iter : directed + random checks against a word model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_shift_reg_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [3:0]  cmd_amt = 4'd0;
  logic [15:0] load_data = 16'd0;
  logic        cmd_ready, shout, busy, done, err;
  logic [15:0] dout;

  int          total = 0;
  int          bad = 0;
  logic [15:0] m_dout = 16'd0;
  logic        m_shout = 1'b0;

  always #5 clk = ~clk;

  shift_reg_iter #(.WIDTH(16), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amt   (cmd_amt),
    .load_data (load_data),
    .dout      (dout),
    .shout     (shout),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-amount model: the result of a chunked shift equals one shift by the full amount.
  task automatic model(input logic [2:0] op, input int amt, input logic [15:0] data,
                       output logic [15:0] ed, output logic es, output logic ee, output int edges);
    ed = m_dout; es = m_shout; ee = 1'b0; edges = 1;
    case (op)
      3'd1: ed = data;
      3'd7: ed = 16'd0;
      3'd2: if (amt > 0) begin ed = m_dout << amt; es = m_dout[16-amt]; edges = (amt + 3) / 4; end
      3'd3: if (amt > 0) begin ed = m_dout >> amt; es = m_dout[amt-1]; edges = (amt + 3) / 4; end
      3'd4: if (amt > 0) begin
              ed = 16'($signed(m_dout) >>> amt); es = m_dout[amt-1]; edges = (amt + 3) / 4;
            end
`ifdef SHIFT_ROTATE_EN
      3'd5: if (amt > 0) begin
              ed = (m_dout << amt) | (m_dout >> (16 - amt)); es = m_dout[16-amt]; edges = (amt + 3) / 4;
            end
      3'd6: if (amt > 0) begin
              ed = (m_dout >> amt) | (m_dout << (16 - amt)); es = m_dout[amt-1]; edges = (amt + 3) / 4;
            end
`else
      3'd5, 3'd6: ee = 1'b1;
`endif
      default: ;
    endcase
  endtask

  task automatic run_cmd(input logic [2:0] op, input int amt, input logic [15:0] data, input string tag);
    logic [15:0] ed;
    logic        es, ee;
    int          edges, n;
    model(op, amt, data, ed, es, ee, edges);
    @(negedge clk);
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt[3:0]; load_data = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    check({tag, ".done"},  32'(done),  32'd1);
    check({tag, ".err"},   32'(err),   32'(ee));
    check({tag, ".dout"},  32'(dout),  32'(ed));
    check({tag, ".shout"}, 32'(shout), 32'(es));
    check({tag, ".edges"}, 32'(n),     32'(edges));
    check({tag, ".idle"},  32'(busy),  32'd0);
    m_dout = ed; m_shout = es;
  endtask

  initial begin
    logic [15:0] ed;
    logic        es, ee;
    int          edges, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.dout",  32'(dout),      32'd0);
    check("rst.shout", 32'(shout),     32'd0);
    check("rst.busy",  32'(busy),      32'd0);
    check("rst.done",  32'(done),      32'd0);
    check("rst.err",   32'(err),       32'd0);
    check("rst.ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;

    run_cmd(3'd1, 0, 16'h8001, "load8001");
    run_cmd(3'd1, 0, 16'h8000, "load8000");
    run_cmd(3'd4, 5, 16'h0000, "sra5");
    check("sra5.value", 32'(dout), 32'h0000FC00);

    // SLL 15 with a LOAD held on the port the whole time it is busy.
    run_cmd(3'd1, 0, 16'h0001, "load0001");
    model(3'd2, 15, 16'h0, ed, es, ee, edges);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 4'd15;
    @(posedge clk);
    #1 cmd_op = 3'd1; load_data = 16'hFFFF;
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      check("held.busy", 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    check("held.edges", 32'(n),    32'd4);
    check("held.dout",  32'(dout), 32'(ed));
    check("held.value", 32'(dout), 32'h00008000);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("held.load_done", 32'(done), 32'd1);
    check("held.load_dout", 32'(dout), 32'h0000FFFF);
    m_dout = 16'hFFFF; m_shout = es;

    // Back-to-back: SRL 0 then LOAD on consecutive edges.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_amt = 4'd0;
    @(posedge clk);
    #1 cmd_op = 3'd1; load_data = 16'h1234;
    @(negedge clk);
    check("b2b.done1", 32'(done),      32'd1);
    check("b2b.dout1", 32'(dout),      32'(m_dout));
    check("b2b.ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b.done2", 32'(done), 32'd1);
    check("b2b.dout2", 32'(dout), 32'h00001234);
    @(negedge clk);
    check("b2b.quiet", 32'(done), 32'd0);
    m_dout = 16'h1234;

    run_cmd(3'd6, 4, 16'h0, "ror4");
    run_cmd(3'd5, 3, 16'h0, "rol3");
    run_cmd(3'd7, 0, 16'h0, "clr");
    run_cmd(3'd1, 0, 16'h7FFF, "load7fff");
    run_cmd(3'd4, 15, 16'h0, "sra15pos");

    for (int i = 0; i < 40; i++) begin
      run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 16'($urandom), "rand");
    end

    // Reset mid-operation aborts immediately and suppresses the completion strobe.
    run_cmd(3'd1, 0, 16'hABCD, "loadabcd");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 4'd12;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("abort.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.dout",  32'(dout),      32'd0);
    check("abort.busy",  32'(busy),      32'd0);
    check("abort.ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort.no_done", 32'(done), 32'd0);
    end
    m_dout = 16'd0; m_shout = 1'b0;
    run_cmd(3'd1, 0, 16'hC3A5, "loadc3a5");
    run_cmd(3'd3, 7, 16'h0, "srl7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
